// File: rtl/arb_mux_pkg.sv
// Shared constants, state/debug types and sizing helper for the arb_mux_n arbitrated output register.
package arb_mux_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;
   localparam int DBG_PTR_W  = 5;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } arb_state_e;

   typedef struct packed {
      arb_state_e           state;
      logic [DBG_PTR_W-1:0] ptr;
      logic                 lock;
   } arb_dbg_t;

   // Index width for n channels; a single channel still needs one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// Request/data inputs and valid/ready output bus of arb_mux_n; master = sources plus consumer, slave = arbiter.
// Handshake: a word moves downstream on a cycle where out_valid && out_ready; gnt[i] marks the cycle din[i] is captured.
interface arb_mux_n_if
   import arb_mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 8
);
   localparam int SELW = clog2_min1(N);

   logic [N-1:0]       req;
   logic [N*WIDTH-1:0] din;
   logic [N-1:0]       gnt;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   dout;
   logic [SELW-1:0]    dout_sel;

   modport master (
      output req, din, out_ready,
      input  gnt, out_valid, dout, dout_sel
   );

   modport slave (
      input  req, din, out_ready,
      output gnt, out_valid, dout, dout_sel
   );

endinterface

// File: rtl/arb_mux_pick.sv
// Combinational rotating-priority picker: first set request searching from ptr upward, wrapping at N-1.
// With mode=0 the search always starts at 0, giving plain lowest-index priority.
module arb_mux_pick
   import arb_mux_pkg::*;
#(
   parameter int N    = 8,
   parameter int SELW = clog2_min1(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   input  logic            mode,
   output logic [N-1:0]    onehot,
   output logic [SELW-1:0] idx,
   output logic            any
);

   int start;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      start  = mode ? int'(ptr) : 0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = start + k;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any       = 1'b1;
            onehot[j] = 1'b1;
            idx       = SELW'(j);
         end
      end
   end

endmodule

// File: rtl/arb_mux_n.sv
// N-to-1 arbitrated output register with valid/ready downstream handshake.
// Optional sticky channel lock is enabled by defining ARB_MUX_LOCK_EN.
module arb_mux_n
   import arb_mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 8,
   parameter int MODE  = MODE_FIXED
) (
   input  logic       clk,
   input  logic       rst,
`ifdef ARB_MUX_LOCK_EN
   input  logic       lock,
`endif
   arb_mux_n_if.slave bus,
   output arb_dbg_t   dbg_o
);

   localparam int SELW = clog2_min1(N);

   arb_state_e       state_q, state_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [SELW-1:0]  sel_q, sel_d;
   logic [SELW-1:0]  ptr_q, ptr_d;
   logic             lock_q, lock_d;

   logic [N-1:0]     sel_mask;
   logic [N-1:0]     eligible;
   logic [N-1:0]     win_onehot;
   logic [SELW-1:0]  win_idx;
   logic             win_any;
   logic [WIDTH-1:0] win_data;
   logic             can_load;
   logic             load;

   always_comb begin
      sel_mask = '0;
      for (int i = 0; i < N; i++) sel_mask[i] = (sel_q == SELW'(i));
   end

   // A held lock narrows the competition to the channel that last won.
   always_comb begin
      eligible = bus.req;
      if (lock_q) eligible = bus.req & sel_mask;
   end

   arb_mux_pick #(
      .N    (N),
      .SELW (SELW)
   ) u_pick (
      .req    (eligible),
      .ptr    (ptr_q),
      .mode   (MODE == MODE_RR),
      .onehot (win_onehot),
      .idx    (win_idx),
      .any    (win_any)
   );

   always_comb begin
      win_data = '0;
      for (int i = 0; i < N; i++)
         if (win_onehot[i]) win_data = win_data | bus.din[i*WIDTH +: WIDTH];
   end

   assign can_load = ((state_q == ST_EMPTY) || bus.out_ready) && !rst;
   assign load     = can_load && win_any;

   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      if (load) begin
         state_d = ST_FULL;
         dout_d  = win_data;
         sel_d   = win_idx;
         if (MODE == MODE_RR)
            ptr_d = (win_idx == SELW'(N-1)) ? '0 : win_idx + SELW'(1);
`ifdef ARB_MUX_LOCK_EN
         lock_d = lock;
`endif
      end else begin
         if ((state_q == ST_FULL) && bus.out_ready) state_d = ST_EMPTY;
         // Locked channel dropped its request: release, grant nothing this cycle.
         if (lock_q && can_load) lock_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         dout_q  <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
      end
   end

   assign bus.gnt       = load ? win_onehot : '0;
   assign bus.out_valid = (state_q == ST_FULL);
   assign bus.dout      = dout_q;
   assign bus.dout_sel  = sel_q;

   assign dbg_o.state = state_q;
   assign dbg_o.ptr   = DBG_PTR_W'(ptr_q);
   assign dbg_o.lock  = lock_q;

endmodule
